// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
//   OP_*  : op_i encodings for MULT/MULTU/DIV/DIVU
//   S_*   : FSM state encodings (IDLE -> CALC -> FIX -> IDLE)
package mips_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate.
//   neg_i    : negate when 1, pass through when 0
//   val_i    : W-bit input value
//   res_c_o  : W-bit result (combinational)
module muldiv_negate #(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] res_c_o
);

    assign res_c_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
//   clk_i, rst_ni           : clock (rising edge), async active-low reset
//   start_i, op_i           : launch MULT/MULTU/DIV/DIVU, sampled only in IDLE
//   rs_val_i, rt_val_i      : multiplicand/dividend, multiplier/divisor
//   mthi_i, mtlo_i, wdata_i : direct HI/LO writes; abort any op in flight
//   busy_o                  : op in flight, HI/LO not yet updated
//   hi_o, lo_o              : HI and LO registers
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [W-1:0] rs_val_i,
    input  logic [W-1:0] rt_val_i,
    input  logic         mthi_i,
    input  logic         mtlo_i,
    input  logic [W-1:0] wdata_i,
    output logic         busy_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam int unsigned CW = $clog2(W);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic           sgn_q, sgn_d;      // product / quotient sign
    logic           rsgn_q, rsgn_d;    // remainder sign
    logic [W-1:0]   dvsr_q, dvsr_d;    // multiplicand or divisor magnitude
    logic [2*W-1:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {rem, dividend/quot}
    logic           busy_q, busy_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    // Operand decode at start
    logic           op_div_c, op_signed_c, div_zero_c, use_mag_c;
    logic [W-1:0]   rs_mag_c, rt_mag_c;

    assign op_div_c    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign op_signed_c = (op_i == OP_MULT) || (op_i == OP_DIV);
    // Divide by zero runs the unsigned path on raw operands so HI ends up as rs.
    assign div_zero_c  = op_div_c && (rt_val_i == '0);
    assign use_mag_c   = op_signed_c && !div_zero_c;

    muldiv_negate #(.W(W)) u_rs_mag (
        .neg_i   (use_mag_c && rs_val_i[W-1]),
        .val_i   (rs_val_i),
        .res_c_o (rs_mag_c)
    );

    muldiv_negate #(.W(W)) u_rt_mag (
        .neg_i   (use_mag_c && rt_val_i[W-1]),
        .val_i   (rt_val_i),
        .res_c_o (rt_mag_c)
    );

    // One shift-add multiply step
    logic [W:0]     mul_sum_c;
    logic [2*W-1:0] mul_next_c;

    assign mul_sum_c  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dvsr_q} : (W+1)'(0));
    assign mul_next_c = {mul_sum_c, acc_q[W-1:1]};

    // One restoring divide step
    logic [W:0]     div_shift_c, div_diff_c;
    logic           div_ok_c;
    logic [2*W-1:0] div_next_c;

    assign div_shift_c = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff_c  = div_shift_c - {1'b0, dvsr_q};
    assign div_ok_c    = !div_diff_c[W];
    assign div_next_c  = {(div_ok_c ? div_diff_c[W-1:0] : div_shift_c[W-1:0]),
                          acc_q[W-2:0], div_ok_c};

    // Result sign fix
    logic [2*W-1:0] prod_fix_c;
    logic [W-1:0]   quot_fix_c, rem_fix_c;

    muldiv_negate #(.W(2*W)) u_prod_fix (
        .neg_i   (sgn_q),
        .val_i   (acc_q),
        .res_c_o (prod_fix_c)
    );

    muldiv_negate #(.W(W)) u_quot_fix (
        .neg_i   (sgn_q),
        .val_i   (acc_q[W-1:0]),
        .res_c_o (quot_fix_c)
    );

    muldiv_negate #(.W(W)) u_rem_fix (
        .neg_i   (rsgn_q),
        .val_i   (acc_q[2*W-1:W]),
        .res_c_o (rem_fix_c)
    );

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        rsgn_d   = rsgn_q;
        dvsr_d   = dvsr_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_CALC;
                    cnt_d    = CW'(W - 1);
                    is_div_d = op_div_c;
                    sgn_d    = use_mag_c && (rs_val_i[W-1] ^ rt_val_i[W-1]);
                    rsgn_d   = use_mag_c && rs_val_i[W-1];
                    dvsr_d   = op_div_c ? rt_mag_c : rs_mag_c;
                    acc_d    = {{W{1'b0}}, (op_div_c ? rs_mag_c : rt_mag_c)};
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next_c : mul_next_c;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix_c;
                    lo_d = quot_fix_c;
                end else begin
                    hi_d = prod_fix_c[2*W-1:W];
                    lo_d = prod_fix_c[W-1:0];
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Direct writes win over everything and abort any op in flight.
        if (mthi_i || mtlo_i) begin
            state_d = S_IDLE;
            if (mthi_i) hi_d = wdata_i;
            if (mtlo_i) lo_d = wdata_i;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            rsgn_q   <= 1'b0;
            dvsr_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            rsgn_q   <= rsgn_d;
            dvsr_q   <= dvsr_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_mips_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mips_muldiv #(.W(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .op_i     (op),
        .rs_val_i (rs_val),
        .rt_val_i (rt_val),
        .mthi_i   (mthi),
        .mtlo_i   (mtlo),
        .wdata_i  (wdata),
        .busy_o   (busy),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] mh, output logic [31:0] ml);
        longint sa, sb, p, q, r;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (mop)
            2'b00: begin
                p  = sa * sb;
                mh = 32'(p >>> 32);
                ml = 32'(p);
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                mh = 32'(up >> 32);
                ml = 32'(up);
            end
            2'b10: begin
                if (b == 32'd0) begin
                    ml = 32'hFFFF_FFFF;
                    mh = a;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    ml = 32'(q);
                    mh = 32'(r);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    ml = 32'hFFFF_FFFF;
                    mh = a;
                end else begin
                    ml = a / b;
                    mh = a % b;
                end
            end
        endcase
    endtask

    // Launch one op, count busy cycles, compare HI/LO. Optionally pulse a
    // second start mid-operation, which must be ignored.
    task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        int cycles;
        logic [31:0] eh, el;
        @(negedge clk);
        start  = 1'b1;
        op     = mop;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            if (inject && cycles == 5) begin
                start  = 1'b1;
                op     = 2'b01;
                rs_val = 32'hFFFF_FFFF;
                rt_val = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            start = 1'b0;
        end
        model(mop, a, b, eh, el);
        check_eq({tag, "_cycles"}, 64'(cycles), 64'd33);
        check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
        check_eq({tag, "_lo"}, 64'(lo), 64'(el));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = '0;
        #12;
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_hi", 64'(hi), 64'd0);
        check_eq("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check_eq("multu_max_lo_const", 64'(lo), 64'h0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check_eq("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check_eq("mult_min_hi_const", 64'(hi), 64'h4000_0000);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        check_eq("divu_100_7_lo_const", 64'(lo), 64'd14);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 1'b0);
        run_op("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
        check_eq("div_zero_hi_const", 64'(hi), 64'hFFFF_FFFB);

        // Start while busy must be ignored
        run_op("inject", 2'b11, 32'd100, 32'd7, 1'b1);

        // MTHI preset, then MTLO aborts a MULTU
        @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'h0000_00AA;
        @(negedge clk);
        mthi = 1'b0;
        check_eq("mthi_hi", 64'(hi), 64'h0000_00AA);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd2;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("abort_busy_before", 64'(busy), 64'd1);
        mtlo  = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        mtlo = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_lo", 64'(lo), 64'h0000_1234);
        check_eq("abort_hi", 64'(hi), 64'h0000_00AA);
        repeat (40) @(negedge clk);
        check_eq("abort_stays_lo", 64'(lo), 64'h0000_1234);
        check_eq("abort_stays_hi", 64'(hi), 64'h0000_00AA);

        // start + mthi together: only the write happens
        start  = 1'b1;
        mthi   = 1'b1;
        op     = 2'b00;
        rs_val = 32'd9;
        rt_val = 32'd9;
        wdata  = 32'h5555_0001;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        check_eq("prio_busy", 64'(busy), 64'd0);
        check_eq("prio_hi", 64'(hi), 64'h5555_0001);
        check_eq("prio_lo", 64'(lo), 64'h0000_1234);
        @(negedge clk);
        check_eq("prio_busy_later", 64'(busy), 64'd0);

        // mthi and mtlo together
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check_eq("both_hi", 64'(hi), 64'hCAFE_F00D);
        check_eq("both_lo", 64'(lo), 64'hCAFE_F00D);

        // Random ops against the model
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            run_op("rand", rop, pick(), pick(), 1'b0);
        end

        // Async reset in the middle of a DIVU
        run_op("pre_reset", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd12345;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_hi", 64'(hi), 64'd0);
        check_eq("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_idle_busy", 64'(busy), 64'd0);
        run_op("post_reset", 2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
